// File: rtl/control_movimiento_multieje.sv
// Round-robin multi-axis motor controller: auto (sensor balance) / manual (position) modes,
// settle window, move timeout faults. Optional macro CTRL_MOV_DEADTIME_EN adds reversal deadtime.
module control_movimiento_multieje #(
  parameter int                N_AXES      = 2,
  parameter int                W           = 16,
  parameter int                DEADBAND    = 5,
  parameter int                SETTLE_CYC  = 4,
  parameter int                TIMEOUT_CYC = 1000,
  parameter int                FULL_TURN   = 360,
  parameter logic [N_AXES-1:0] WRAP_MASK   = 'b01,
  parameter int                DEADTIME    = 2,
  localparam int               AW          = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sma,
  input  logic [N_AXES*W-1:0] sens_a,
  input  logic [N_AXES*W-1:0] sens_b,
  input  logic [N_AXES*W-1:0] pos_target,
  input  logic [N_AXES*W-1:0] pos_actual,
  input  logic                fault_clr,
  output logic [N_AXES-1:0]   drv_pos,
  output logic [N_AXES-1:0]   drv_neg,
  output logic [AW-1:0]       active_axis,
  output logic                busy,
  output logic [N_AXES-1:0]   fault
);

  localparam int         MW   = $clog2(TIMEOUT_CYC + 1);
  localparam int         SW   = $clog2(SETTLE_CYC + 1);
  localparam logic [W:0] HALF = (W+1)'(FULL_TURN / 2);
  localparam logic [W:0] TURN = (W+1)'(FULL_TURN);
  localparam logic [W:0] DB   = (W+1)'(DEADBAND);

  if (N_AXES < 1 || N_AXES > 8 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1 || DEADTIME < 0) begin : g_param_err
    $error("control_movimiento_multieje: parameter out of range");
  end

  typedef enum logic {ST_MOVE, ST_SETTLE} state_t;

  logic [N_AXES-1:0][W:0] w_e;
  logic [N_AXES-1:0]      w_dpos;

  for (genvar i = 0; i < N_AXES; i++) begin : g_ax
    logic [W-1:0] w_a, w_b;
    logic [W:0]   w_mag;
    logic         w_gt, w_wrap;
    assign w_a    = sma ? pos_actual[i*W +: W] : sens_a[i*W +: W];
    assign w_b    = sma ? pos_target[i*W +: W] : sens_b[i*W +: W];
    assign w_gt   = w_a > w_b;
    assign w_mag  = w_gt ? ({1'b0, w_a} - {1'b0, w_b}) : ({1'b0, w_b} - {1'b0, w_a});
    assign w_wrap = sma && WRAP_MASK[i] && (w_mag > HALF);
    // shortcut the other way round; saturate so out-of-range positions never underflow
    assign w_e[i]    = !w_wrap ? w_mag : ((w_mag >= TURN) ? '0 : (TURN - w_mag));
    assign w_dpos[i] = w_gt ^ w_wrap;
  end

  state_t            r_state, w_state_n;
  logic [AW-1:0]     r_axis, w_axis_n;
  logic [MW-1:0]     r_mcnt, w_mcnt_n;
  logic [SW-1:0]     r_scnt, w_scnt_n;
  logic [N_AXES-1:0] r_drv_pos, r_drv_neg, w_drv_pos_n, w_drv_neg_n;
  logic [N_AXES-1:0] r_fault, w_fset;
  logic              r_busy, w_busy_n, r_mode, r_mvld;
  logic              w_mchg, w_adv, w_inb, w_dir, w_go;
  logic [W:0]        w_err;

`ifdef CTRL_MOV_DEADTIME_EN
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  logic [DW-1:0]          r_dcnt, w_dcnt_n;
  logic [N_AXES-1:0][1:0] r_last, w_last_n;
  logic [1:0]             w_want;
  assign w_want = w_dir ? 2'b01 : 2'b10;
`endif

  assign w_err  = w_e[r_axis];
  assign w_dir  = w_dpos[r_axis];
  assign w_inb  = w_err <= DB;
  assign w_mchg = r_mvld && (sma != r_mode);

  always_comb begin
    w_state_n   = r_state;
    w_axis_n    = r_axis;
    w_mcnt_n    = r_mcnt;
    w_scnt_n    = r_scnt;
    w_drv_pos_n = '0;
    w_drv_neg_n = '0;
    w_fset      = '0;
    w_adv       = 1'b0;
    w_go        = 1'b0;
`ifdef CTRL_MOV_DEADTIME_EN
    w_dcnt_n    = '0;
    w_last_n    = r_last;
`endif
    if (w_mchg) begin
      w_state_n = ST_MOVE;
      w_axis_n  = '0;
      w_mcnt_n  = '0;
      w_scnt_n  = '0;
    end else begin
      case (r_state)
        ST_MOVE: begin
          if (w_inb) begin
            w_state_n = ST_SETTLE;
            w_scnt_n  = '0;
          end else if (r_mcnt == MW'(TIMEOUT_CYC - 1)) begin
            w_fset[r_axis] = 1'b1;
            w_adv          = 1'b1;
          end else begin
            w_mcnt_n = r_mcnt + 1'b1;
`ifdef CTRL_MOV_DEADTIME_EN
            // reversal: idle the bridge before driving the opposite way
            if (r_last[r_axis] != 2'b00 && r_last[r_axis] != w_want && r_dcnt < DW'(DEADTIME)) begin
              w_dcnt_n = r_dcnt + 1'b1;
            end else begin
              w_go             = 1'b1;
              w_last_n[r_axis] = w_want;
            end
`else
            w_go = 1'b1;
`endif
          end
        end
        default: begin
          if (!w_inb)                             w_state_n = ST_MOVE;
          else if (r_scnt == SW'(SETTLE_CYC - 1)) w_adv     = 1'b1;
          else                                    w_scnt_n  = r_scnt + 1'b1;
        end
      endcase
    end
    if (w_adv) begin
      w_state_n = ST_MOVE;
      w_axis_n  = (r_axis == AW'(N_AXES - 1)) ? '0 : r_axis + 1'b1;
      w_mcnt_n  = '0;
      w_scnt_n  = '0;
    end
    if (w_go) begin
      w_drv_pos_n[r_axis] = w_dir;
      w_drv_neg_n[r_axis] = !w_dir;
    end
    w_busy_n = (w_state_n == ST_MOVE) && !w_inb && !w_adv && !w_mchg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_MOVE;
      r_axis    <= '0;
      r_mcnt    <= '0;
      r_scnt    <= '0;
      r_drv_pos <= '0;
      r_drv_neg <= '0;
      r_fault   <= '0;
      r_busy    <= 1'b0;
      r_mode    <= 1'b0;
      r_mvld    <= 1'b0;
`ifdef CTRL_MOV_DEADTIME_EN
      r_dcnt    <= '0;
      r_last    <= '0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_axis    <= w_axis_n;
      r_mcnt    <= w_mcnt_n;
      r_scnt    <= w_scnt_n;
      r_drv_pos <= w_drv_pos_n;
      r_drv_neg <= w_drv_neg_n;
      r_fault   <= (r_fault & ~{N_AXES{fault_clr}}) | w_fset;
      r_busy    <= w_busy_n;
      r_mode    <= sma;
      r_mvld    <= 1'b1;
`ifdef CTRL_MOV_DEADTIME_EN
      r_dcnt    <= w_dcnt_n;
      r_last    <= w_last_n;
`endif
    end
  end

  assign drv_pos     = r_drv_pos;
  assign drv_neg     = r_drv_neg;
  assign active_axis = r_axis;
  assign busy        = r_busy;
  assign fault       = r_fault;

endmodule
